// File: rtl/gun_fire_ctrl.sv
// Per-channel light-gun trigger-to-shot controller: synchroniser, firing FSM, ammo and cooldown.
// Optional TRIGGER_DEBOUNCE_EN adds a DEBOUNCE-cycle stability filter after the synchroniser.
module gun_fire_ctrl #(
  parameter int CHANNELS = 2,
  parameter int AMMO_MAX = 3,
  parameter int COOLDOWN = 4,
  parameter int DEBOUNCE = 8,
  localparam int AW = $clog2(AMMO_MAX + 1)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [CHANNELS-1:0]    trigger,
  input  logic [CHANNELS-1:0]    reload,
  input  logic                   round_clr,
  output logic [CHANNELS-1:0]    shot,
  output logic [CHANNELS-1:0]    empty,
  output logic [CHANNELS*AW-1:0] ammo,
  output logic [CHANNELS*3-1:0]  state
);

  typedef enum logic [2:0] {
    S_RELOAD = 3'b000,
    S_HOLD   = 3'b001,
    S_COOL   = 3'b010,
    S_SHOT   = 3'b011,
    S_EMPTY  = 3'b100
  } state_e;

  // Counter holds at most COOLDOWN-1; keep at least one bit when COOLDOWN is 0 or 1.
  localparam int CW = (COOLDOWN < 2) ? 1 : $clog2(COOLDOWN);
  localparam logic [AW-1:0] AMMO_FULL = AW'(AMMO_MAX);

  if (CHANNELS < 1 || CHANNELS > 8 || AMMO_MAX < 1 || AMMO_MAX > 15 ||
      COOLDOWN < 0 || DEBOUNCE < 1) begin : g_bad_param
    $error("gun_fire_ctrl: parameter out of range");
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [1:0]    sync_q, sync_d;
    logic          trig_q;
    state_e        state_q, state_d;
    logic [AW-1:0] ammo_q, ammo_d;
    logic [CW-1:0] cool_q, cool_d;
    logic          shot_q, shot_d;
    logic          empty_q, empty_d;

    // sync_q[1] is the metastability-settled trigger level.
    always_comb begin
      sync_d = {sync_q[0], trigger[i]};
    end

    // NOTE: reset is in the sensitivity list, so it takes effect without a clock edge.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        sync_q <= '0;
      end else begin
        // NOTE: non-blocking so every flop samples pre-edge values; blocking here would collapse the chain.
        sync_q <= sync_d;
      end
    end

`ifdef TRIGGER_DEBOUNCE_EN
    localparam int DW = $clog2(DEBOUNCE + 1);
    logic          trig_d;
    logic [DW-1:0] db_q, db_d;

    // trig_q follows the synchronised level only after DEBOUNCE consecutive disagreeing cycles.
    always_comb begin
      trig_d = trig_q;
      db_d   = '0;
      if (sync_q[1] != trig_q) begin
        if (db_q == DW'(DEBOUNCE - 1)) trig_d = sync_q[1];
        else                           db_d   = db_q + DW'(1);
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        trig_q <= 1'b0;
        db_q   <= '0;
      end else begin
        trig_q <= trig_d;
        db_q   <= db_d;
      end
    end
`else
    assign trig_q = sync_q[1];
`endif

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state_q <= S_RELOAD;
        ammo_q  <= AMMO_FULL;
        cool_q  <= '0;
      end else begin
        state_q <= state_d;
        ammo_q  <= ammo_d;
        cool_q  <= cool_d;
      end
    end

    always_comb begin
      // NOTE: defaults first give every path a value, so no latch is inferred.
      state_d = state_q;
      ammo_d  = ammo_q;
      cool_d  = cool_q;
      case (state_q)
        S_RELOAD: if (!trig_q) state_d = (ammo_q != '0) ? S_HOLD : S_EMPTY;
        S_HOLD: begin
          if (trig_q) begin
            state_d = S_SHOT;
            ammo_d  = ammo_q - AW'(1);
          end
        end
        S_SHOT: begin
          if (COOLDOWN == 0) begin
            state_d = S_RELOAD;
          end else begin
            state_d = S_COOL;
            cool_d  = CW'(COOLDOWN - 1);
          end
        end
        S_COOL: begin
          if (cool_q == '0) state_d = S_RELOAD;
          else              cool_d  = cool_q - CW'(1);
        end
        S_EMPTY: if (reload[i]) state_d = S_RELOAD;
        default: state_d = S_RELOAD;
      endcase
      // A refill overrides a same-edge decrement; the shot itself still fires.
      if (reload[i]) ammo_d = AMMO_FULL;
      if (round_clr) begin
        state_d = S_RELOAD;
        ammo_d  = AMMO_FULL;
        cool_d  = '0;
      end
    end

    // Outputs decoded from the next state and registered, so they are glitch-free.
    always_comb begin
      shot_d  = (state_d == S_SHOT);
      empty_d = (state_d == S_EMPTY);
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        shot_q  <= 1'b0;
        empty_q <= 1'b0;
      end else begin
        shot_q  <= shot_d;
        empty_q <= empty_d;
      end
    end

    assign shot[i]            = shot_q;
    assign empty[i]           = empty_q;
    assign ammo[i*AW +: AW]   = ammo_q;
    assign state[i*3 +: 3]    = state_q;
  end

endmodule
